// File: rtl/frame_scheduler.sv
// ---------------------------------------------------------------------------
// frame_scheduler
//
// Purpose:
//   Walks one image frame through the ray generator / ray processor pair.
//   Pixel coordinates are issued in raster order under a valid/ready
//   handshake, and the number of rays in flight is bounded by a credit
//   counter. Results come back in request order, are buffered in a small
//   in-order FIFO, and leave as a pixel stream tagged with start-of-frame
//   and end-of-line markers.
//
// Ports:
//   clk, reset_n                   clock, asynchronous active-low reset
//   start, cfg_width, cfg_height   frame request and image dimensions
//   busy, frame_done, cfg_err      frame status (done/err are 1-cycle pulses)
//   req_valid/req_ready/req_x/req_y    ray request channel
//   rsp_valid, rsp_r/g/b           in-order ray results (no back-pressure)
//   out_valid/out_ready/out_data   pixel output stream, data = {r,g,b}
//   out_sof, out_eol               frame/line markers, qualified by out_valid
// ---------------------------------------------------------------------------
module frame_scheduler #(
  parameter int CNT_W           = 13,
  parameter int COLOR_W         = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [CNT_W-1:0]     cfg_width,
  input  logic [CNT_W-1:0]     cfg_height,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 cfg_err,
  output logic                 req_valid,
  input  logic                 req_ready,
  output logic [CNT_W-1:0]     req_x,
  output logic [CNT_W-1:0]     req_y,
  input  logic                 rsp_valid,
  input  logic [COLOR_W-1:0]   rsp_r,
  input  logic [COLOR_W-1:0]   rsp_g,
  input  logic [COLOR_W-1:0]   rsp_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3*COLOR_W-1:0] out_data,
  output logic                 out_sof,
  output logic                 out_eol
);

  localparam int CRED_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W  = $clog2(MAX_OUTSTANDING);
  localparam int DATA_W = 3 * COLOR_W;

  localparam logic [CNT_W-1:0]  ONE_C      = CNT_W'(1);
  localparam logic [CRED_W-1:0] ONE_CR     = CRED_W'(1);
  localparam logic [CRED_W-1:0] MAX_CRED   = CRED_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0]  ONE_P      = PTR_W'(1);
  localparam logic [PTR_W:0]    ONE_N      = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]    FIFO_DEPTH = (PTR_W + 1)'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t              r_state;
  logic [CNT_W-1:0]    r_width;
  logic [CNT_W-1:0]    r_height;
  logic [CNT_W-1:0]    r_x;
  logic [CNT_W-1:0]    r_y;
  logic                r_busy;
  logic                r_frame_done;
  logic                r_cfg_err;

  logic [CRED_W-1:0]   r_credits;

  logic [DATA_W-1:0]   r_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [PTR_W:0]      r_count;

  logic [CNT_W-1:0]    r_ocol;
  logic [CNT_W-1:0]    r_orow;

  // -------------------------------------------------------------------------
  // Combinational decode
  // -------------------------------------------------------------------------
  logic                w_idle;
  logic                w_dim_zero;
  logic                w_start_ok;
  logic                w_start_bad;
  logic                w_req_valid;
  logic                w_req_fire;
  logic                w_out_valid;
  logic                w_out_fire;
  logic                w_fifo_full;
  logic                w_rsp_block;
  logic                w_push;
  logic                w_x_last;
  logic                w_y_last;
  logic                w_ocol_last;
  logic [DATA_W-1:0]   w_rsp_data;

  assign w_idle      = (r_state == S_IDLE);
  assign w_dim_zero  = (cfg_width == '0) || (cfg_height == '0);
  assign w_start_ok  = w_idle && start && !w_dim_zero;
  assign w_start_bad = w_idle && start && w_dim_zero;

  assign w_req_valid = (r_state == S_ISSUE) && (r_credits < MAX_CRED);
  assign w_req_fire  = w_req_valid && req_ready;

  assign w_out_valid = (r_count != '0);
  assign w_out_fire  = w_out_valid && out_ready;

  // A full FIFO can still take a result if a pop frees a slot this cycle.
  // An idle scheduler with no credits has nothing in flight, so anything
  // arriving then (e.g. stragglers from a frame aborted by reset) is stale.
  assign w_fifo_full = (r_count == FIFO_DEPTH);
  assign w_rsp_block = w_idle && (r_credits == '0);
  assign w_push      = rsp_valid && !w_rsp_block && (!w_fifo_full || w_out_fire);
  assign w_rsp_data  = {rsp_r, rsp_g, rsp_b};

  assign w_x_last    = (r_x == r_width - ONE_C);
  assign w_y_last    = (r_y == r_height - ONE_C);
  assign w_ocol_last = (r_ocol == r_width - ONE_C);

  // -------------------------------------------------------------------------
  // Frame sequencing FSM and request coordinates
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_width      <= '0;
      r_height     <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_cfg_err    <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_cfg_err    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start_bad) begin
            r_cfg_err <= 1'b1;
          end else if (w_start_ok) begin
            r_width  <= cfg_width;
            r_height <= cfg_height;
            r_x      <= '0;
            r_y      <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_req_fire) begin
            if (w_x_last) begin
              r_x <= '0;
              if (w_y_last) begin
                r_state <= S_DRAIN;
              end else begin
                r_y <= r_y + ONE_C;
              end
            end else begin
              r_x <= r_x + ONE_C;
            end
          end
        end
        S_DRAIN: begin
          // Zero credits means every issued ray has also left on the output.
          if ((r_credits == '0) && (r_count == '0)) begin
            r_busy       <= 1'b0;
            r_frame_done <= 1'b1;
            r_state      <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Credit counter: one credit per ray from request until its pixel leaves.
  // Holding it at MAX_OUTSTANDING also guarantees the FIFO never overflows.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_credits <= '0;
    end else if (w_start_ok) begin
      r_credits <= '0;
    end else begin
      case ({w_req_fire, w_out_fire})
        2'b10:   r_credits <= r_credits + ONE_CR;
        2'b01:   r_credits <= r_credits - ONE_CR;
        default: r_credits <= r_credits;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Result FIFO. Storage needs no reset: r_count gates everything visible.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_rsp_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_start_ok) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + ONE_P;
      end
      if (w_out_fire) begin
        r_rd_ptr <= r_rd_ptr + ONE_P;
      end
      case ({w_push, w_out_fire})
        2'b10:   r_count <= r_count + ONE_N;
        2'b01:   r_count <= r_count - ONE_N;
        default: r_count <= r_count;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Output position counters for the frame/line markers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ocol <= '0;
      r_orow <= '0;
    end else if (w_start_ok) begin
      r_ocol <= '0;
      r_orow <= '0;
    end else if (w_out_fire) begin
      if (w_ocol_last) begin
        r_ocol <= '0;
        r_orow <= r_orow + ONE_C;
      end else begin
        r_ocol <= r_ocol + ONE_C;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs. Everything below is decoded from registers only, so it holds
  // steady under back-pressure and drops to zero the moment reset asserts.
  // -------------------------------------------------------------------------
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign cfg_err    = r_cfg_err;

  assign req_valid  = w_req_valid;
  assign req_x      = r_x;
  assign req_y      = r_y;

  assign out_valid  = w_out_valid;
  assign out_data   = w_out_valid ? r_mem[r_rd_ptr] : '0;
  assign out_sof    = w_out_valid && (r_ocol == '0) && (r_orow == '0);
  assign out_eol    = w_out_valid && w_ocol_last;

endmodule

// File: tb/tb_frame_scheduler.sv
`timescale 1ns/1ps
module tb_frame_scheduler;

  localparam int CNT_W   = 13;
  localparam int COLOR_W = 8;
  localparam int MAXO    = 4;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 start = 1'b0;
  logic [CNT_W-1:0]     cfg_width = '0;
  logic [CNT_W-1:0]     cfg_height = '0;
  logic                 busy;
  logic                 frame_done;
  logic                 cfg_err;
  logic                 req_valid;
  logic                 req_ready = 1'b0;
  logic [CNT_W-1:0]     req_x;
  logic [CNT_W-1:0]     req_y;
  logic                 rsp_valid = 1'b0;
  logic [COLOR_W-1:0]   rsp_r = '0;
  logic [COLOR_W-1:0]   rsp_g = '0;
  logic [COLOR_W-1:0]   rsp_b = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [3*COLOR_W-1:0] out_data;
  logic                 out_sof;
  logic                 out_eol;

  frame_scheduler #(
    .CNT_W(CNT_W), .COLOR_W(COLOR_W), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .cfg_width(cfg_width), .cfg_height(cfg_height),
    .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err),
    .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
    .rsp_valid(rsp_valid), .rsp_r(rsp_r), .rsp_g(rsp_g), .rsp_b(rsp_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sof(out_sof), .out_eol(out_eol)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Ray pipeline model: each accepted request returns a colour rsp_delay
  // cycles later, encoded from its coordinates and a per-frame tag.
  int          rsp_delay = 2;
  logic [7:0]  tag = 8'h50;
  int          due_q[$];
  logic [23:0] dat_q[$];

  initial begin : responder
    logic [7:0] rx, ry;
    forever begin
      @(negedge clk);
      #1;
      rsp_valid = 1'b0;
      {rsp_r, rsp_g, rsp_b} = 24'h0;
      if (due_q.size() > 0 && due_q[0] == cyc + 1) begin
        rsp_valid = 1'b1;
        {rsp_r, rsp_g, rsp_b} = dat_q[0];
        void'(due_q.pop_front());
        void'(dat_q.pop_front());
      end
      if (req_valid && req_ready) begin
        rx = req_x[7:0] + 8'h11;
        ry = req_y[7:0] + 8'h22;
        due_q.push_back(cyc + 1 + rsp_delay);
        dat_q.push_back({rx, ry, tag});
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: bench did not finish, required finish before 2ms");
    $fatal(1, "bench timeout");
  end

  // Drives one frame from an IDLE scheduler and checks every request and
  // output pixel against raster order; returns frame statistics.
  task automatic run_frame(
    input int w, input int h, input int d, input int stall, input bit rdy_mode,
    input int mid_start, input int abort_after, input int budget,
    output int n_req, output int n_out, output int n_done, output int max_os,
    output int busy_bad, output int req_at_first_out, output int done_at_out);
    int ex_x, ex_y, idx, post;
    bit done_seen;
    logic [7:0]  xv, yv;
    logic [23:0] exp_d;
    logic exp_sof, exp_eol;
    rsp_delay = d;
    tag = tag + 8'h01;
    n_req = 0; n_out = 0; n_done = 0; max_os = 0; busy_bad = 0;
    req_at_first_out = -1; done_at_out = -1;
    ex_x = 0; ex_y = 0; idx = 0; post = 0; done_seen = 1'b0;
    cfg_width = CNT_W'(w);
    cfg_height = CNT_W'(h);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < budget; c++) begin
      out_ready  = (c >= stall);
      req_ready  = rdy_mode ? ((c % 3) != 2) : 1'b1;
      start      = (c == mid_start);
      cfg_width  = (c == mid_start) ? CNT_W'(1) : CNT_W'(w);
      cfg_height = (c == mid_start) ? CNT_W'(1) : CNT_W'(h);
      if (frame_done) begin
        n_done++;
        if (!done_seen) done_at_out = n_out;
        done_seen = 1'b1;
      end
      if (busy !== !done_seen) busy_bad++;
      if (req_valid) begin
        checks++;
        if (req_x !== CNT_W'(ex_x) || req_y !== CNT_W'(ey_of(ex_y))) begin
          failures++;
          $display("FAIL req_coord: got (%0d,%0d) required (%0d,%0d)", req_x, req_y, ex_x, ex_y);
        end
        if (req_ready) begin
          $display("REQ  x=%0d y=%0d", req_x, req_y);
          n_req++;
          ex_x++;
          if (ex_x == w) begin ex_x = 0; ex_y++; end
        end
      end
      if (out_valid) begin
        xv = 8'(idx % w);
        yv = 8'(idx / w);
        exp_d = {xv + 8'h11, yv + 8'h22, tag};
        exp_sof = (idx == 0);
        exp_eol = ((idx % w) == w - 1);
        checks++;
        if (out_data !== exp_d || out_sof !== exp_sof || out_eol !== exp_eol) begin
          failures++;
          $display("FAIL out_pixel %0d: got data=%h sof=%b eol=%b required data=%h sof=%b eol=%b",
                   idx, out_data, out_sof, out_eol, exp_d, exp_sof, exp_eol);
        end
        if (out_ready) begin
          $display("OUT  idx=%0d data=%h sof=%b eol=%b", idx, out_data, out_sof, out_eol);
          if (req_at_first_out < 0) req_at_first_out = n_req;
          n_out++;
          idx++;
        end
      end
      if (n_req - n_out > max_os) max_os = n_req - n_out;
      if (abort_after > 0 && n_out == abort_after) begin
        start = 1'b0;
        return;
      end
      if (done_seen) begin
        post++;
        if (post > 5) return;
      end
      @(negedge clk);
    end
    checks++;
    failures++;
    $display("FAIL run_frame_timeout: frame %0dx%0d out=%0d done=%0d after %0d cycles, required completion",
             w, h, n_out, n_done, budget);
  endtask

  function automatic int ey_of(input int y);
    return y;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, frame_done, cfg_err, req_valid, out_valid, out_sof, out_eol} !== 7'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b required 0000000",
               {busy, frame_done, cfg_err, req_valid, out_valid, out_sof, out_eol});
    end
    checks++;
    if (req_x !== '0 || req_y !== '0) begin
      failures++;
      $display("FAIL reset_coord: got (%0d,%0d) required (0,0)", req_x, req_y);
    end
    checks++;
    if (out_data !== '0) begin
      failures++;
      $display("FAIL reset_data: got %h required 000000", out_data);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_frame_4x2();
    int nr, no, nd, mo, bb, rf, da;
    run_frame(4, 2, 2, 0, 1'b0, -1, 0, 200, nr, no, nd, mo, bb, rf, da);
    checks++; if (nr !== 8) begin failures++; $display("FAIL f4x2_requests: got %0d required 8", nr); end
    checks++; if (no !== 8) begin failures++; $display("FAIL f4x2_outputs: got %0d required 8", no); end
    checks++; if (nd !== 1) begin failures++; $display("FAIL f4x2_done_pulses: got %0d required 1", nd); end
    checks++; if (da !== 8) begin failures++; $display("FAIL f4x2_done_after: got %0d outputs required 8", da); end
    checks++; if (bb !== 0) begin failures++; $display("FAIL f4x2_busy: got %0d bad cycles required 0", bb); end
    checks++; if (mo > MAXO) begin failures++; $display("FAIL f4x2_credits: got %0d required <= 4", mo); end
  endtask

  task automatic test_credit_limit();
    int nr, no, nd, mo, bb, rf, da;
    run_frame(3, 3, 20, 0, 1'b0, -1, 0, 400, nr, no, nd, mo, bb, rf, da);
    checks++; if (rf !== 4) begin failures++; $display("FAIL credit_first_burst: got %0d requests required 4", rf); end
    checks++; if (mo !== 4) begin failures++; $display("FAIL credit_max: got %0d required 4", mo); end
    checks++; if (no !== 9) begin failures++; $display("FAIL credit_outputs: got %0d required 9", no); end
    checks++; if (nd !== 1) begin failures++; $display("FAIL credit_done: got %0d required 1", nd); end
  endtask

  task automatic test_backpressure();
    int nr, no, nd, mo, bb, rf, da;
    run_frame(2, 2, 2, 30, 1'b0, -1, 0, 300, nr, no, nd, mo, bb, rf, da);
    checks++; if (mo !== 4) begin failures++; $display("FAIL bp_buffered: got %0d required 4", mo); end
    checks++; if (no !== 4) begin failures++; $display("FAIL bp_outputs: got %0d required 4", no); end
    checks++; if (da !== 4) begin failures++; $display("FAIL bp_done_after: got %0d required 4", da); end
    checks++; if (nd !== 1) begin failures++; $display("FAIL bp_done: got %0d required 1", nd); end
  endtask

  task automatic test_cfg_err();
    int bad;
    for (int k = 0; k < 2; k++) begin
      cfg_width  = (k == 0) ? CNT_W'(0) : CNT_W'(3);
      cfg_height = (k == 0) ? CNT_W'(5) : CNT_W'(0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if ({cfg_err, busy, req_valid} !== 3'b100) begin
        failures++;
        $display("FAIL cfg_err_pulse %0d: got err,busy,req=%b required 100", k, {cfg_err, busy, req_valid});
      end
      bad = 0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (cfg_err || busy || req_valid) bad++;
      end
      checks++;
      if (bad !== 0) begin
        failures++;
        $display("FAIL cfg_err_after %0d: got %0d bad cycles required 0", k, bad);
      end
    end
  endtask

  task automatic test_mid_start();
    int nr, no, nd, mo, bb, rf, da;
    run_frame(3, 2, 3, 0, 1'b1, 4, 0, 300, nr, no, nd, mo, bb, rf, da);
    checks++; if (nr !== 6) begin failures++; $display("FAIL mid_requests: got %0d required 6", nr); end
    checks++; if (no !== 6) begin failures++; $display("FAIL mid_outputs: got %0d required 6", no); end
    checks++; if (nd !== 1) begin failures++; $display("FAIL mid_done: got %0d required 1", nd); end
    checks++; if (bb !== 0) begin failures++; $display("FAIL mid_busy: got %0d bad cycles required 0", bb); end
  endtask

  task automatic test_abort_reset();
    int nr, no, nd, mo, bb, rf, da, bad;
    run_frame(4, 2, 6, 0, 1'b0, -1, 3, 200, nr, no, nd, mo, bb, rf, da);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, frame_done, cfg_err, req_valid, out_valid, out_sof, out_eol} !== 7'b0 || out_data !== '0) begin
      failures++;
      $display("FAIL abort_outputs: got flags=%b data=%h required all zero",
               {busy, frame_done, cfg_err, req_valid, out_valid, out_sof, out_eol}, out_data);
    end
    @(negedge clk);
    reset_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (frame_done || out_valid || busy) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL abort_quiet: got %0d active cycles required 0", bad);
    end
    run_frame(1, 1, 2, 0, 1'b0, -1, 0, 100, nr, no, nd, mo, bb, rf, da);
    checks++; if (no !== 1) begin failures++; $display("FAIL post_abort_outputs: got %0d required 1", no); end
    checks++; if (nd !== 1) begin failures++; $display("FAIL post_abort_done: got %0d required 1", nd); end
    checks++; if (da !== 1) begin failures++; $display("FAIL post_abort_done_after: got %0d required 1", da); end
  endtask

  initial begin : main
    test_reset();
    test_frame_4x2();
    test_credit_limit();
    test_backpressure();
    test_cfg_err();
    test_mid_start();
    test_abort_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_scheduler.md
Name: frame_scheduler

Overview:
- Sequences one full frame through the ray generator / ray processor pair.
- Issues pixel coordinates in raster order under a valid/ready handshake and limits in-flight rays with a credit counter.
- Buffers returned RGB results in an in-order FIFO and emits them as a pixel stream with start-of-frame and end-of-line markers.
- Sits between the host/config logic and the ray tracing unit, and owns frame start/busy/done.

Parameters:
- CNT_W, 13, width of image dimension and coordinate fields.
- COLOR_W, 8, width of each colour channel.
- MAX_OUTSTANDING, 4, maximum number of issued rays not yet emitted on the output; also the result FIFO depth (power of 2, at least 2).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle frame start request; sampled only in IDLE.
- cfg_width  in  CNT_W  image width in pixels; latched on an accepted start.
- cfg_height  in  CNT_W  image height in pixels; latched on an accepted start.
- busy  out  1  high in ISSUE and DRAIN.
- frame_done  out  1  one-cycle pulse after the last pixel of the frame is emitted.
- cfg_err  out  1  one-cycle pulse when start is given with a zero dimension.
- req_valid  out  1  ray request valid.
- req_ready  in  1  ray pipeline accepts the request.
- req_x  out  CNT_W  pixel column of the request.
- req_y  out  CNT_W  pixel row of the request.
- rsp_valid  in  1  pixel result valid; results return in request order; there is no back-pressure on this input.
- rsp_r, rsp_g, rsp_b  in  COLOR_W each  pixel result colour channels.
- out_valid  out  1  output pixel valid.
- out_ready  in  1  downstream accepts the output pixel.
- out_data  out  3*COLOR_W  output pixel packed as {r,g,b}.
- out_sof  out  1  marks pixel (0,0) of the frame; qualified by out_valid.
- out_eol  out  1  marks the last pixel of each row; qualified by out_valid.

Behaviour:
- Reset (asynchronous, active-low) clears everything:
  - state=IDLE.
  - All outputs 0.
  - Counters, credits and the FIFO cleared.
  - Latched width/height = 0.
- Reset mid-frame aborts the frame:
  - No frame_done is generated.
  - FIFO contents are discarded.
  - Responses arriving during or after reset are ignored until a new frame starts.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1 with cfg_width=0 or cfg_height=0 → cfg_err pulses next cycle; stay in IDLE.
  - start=1 with both dimensions nonzero → latch width/height, clear all counters → ISSUE.
- ISSUE:
  - req_valid=1 whenever credits < MAX_OUTSTANDING.
  - A request transfers when req_valid & req_ready.
  - req_x/req_y hold stable while req_valid=1 and req_ready=0.
  - After a transfer, x increments. At x=width-1, x wraps to 0 and y increments.
  - The transfer of (width-1, height-1) → DRAIN, with req_valid=0 from the next cycle.
- DRAIN: when credits=0 and the FIFO is empty → DONE.
- DONE: frame_done=1 for one cycle → IDLE.
- start in any non-IDLE state is ignored.
- Latency: a start accepted at cycle T gives req_valid=1 at T+1 (if credits allow).
- Credits:
  - Increment on a request transfer; decrement on an output transfer (out_valid & out_ready).
  - Both in the same cycle → unchanged.
  - Never exceeds MAX_OUTSTANDING, so the FIFO cannot overflow.
- Result FIFO:
  - Depth MAX_OUTSTANDING; rsp_valid pushes {rsp_r,rsp_g,rsp_b}.
  - Push and pop in the same cycle are both allowed, including when full (pop frees the slot).
  - rsp_valid while the FIFO is full, or while credits=0 in IDLE, is a protocol violation; the data is dropped and the FIFO is unchanged.
- Output stream:
  - out_valid = FIFO non-empty (registered). A push into an empty FIFO at cycle T gives out_valid at T+1.
  - out_data, out_sof and out_eol hold stable while out_valid=1 and out_ready=0.
  - Output column/row counters advance on each output transfer.
  - out_sof=1 when the output counter is (0,0).
  - out_eol=1 when the output column = width-1.
- Widths: coordinates are CNT_W bits unsigned; credits use clog2(MAX_OUTSTANDING+1) bits.
- Maximum frame: (2^CNT_W-1)² pixels; no counter wraps within a legal frame.

Test Plan:
- 4x2 frame, req_ready=1, rsp_valid 2 cycles after each request, out_ready=1:
  - Requests in order (0,0)…(3,0),(0,1)…(3,1).
  - 8 outputs; out_sof on the 1st only; out_eol on the 4th and 8th.
  - frame_done pulses once; busy=1 from start+1 until frame_done.
- 3x3 frame, responses delayed 20 cycles, out_ready=1:
  - Exactly 4 requests issue, then req_valid=0 until the first output transfers.
  - Credits never exceed 4.
- 2x2 frame, out_ready=0 for 30 cycles then 1:
  - FIFO holds 4 results; out_data stable while stalled.
  - Pixels emitted in order after release; frame_done follows the 4th output.
- start with cfg_width=0, cfg_height=5 → cfg_err for 1 cycle; busy stays 0; no req_valid.
- Frame running:
  - Pulse start mid-frame → ignored; request/response sequence unchanged.
  - Assert reset_n=0 after 3 outputs → all outputs 0 immediately; no frame_done; a new 1x1 frame then completes normally with out_sof=out_eol=1.
